// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between the ALU/load requesters, the arbiter and the register file write port.
// The master side drives the requests; the slave side (the arbiter) drives readies, the write port and the busy mask.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
);
  logic                alu_valid;
  logic                alu_ready;
  logic [ADDR_W-1:0]   alu_rd;
  logic [DATA_W-1:0]   alu_data;
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_rd;
  logic [DATA_W-1:0]   mem_data;
  logic                write_enable;
  logic [ADDR_W-1:0]   write_reg;
  logic [DATA_W-1:0]   data_in;
  logic [NUM_REGS-1:0] busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, write_enable, write_reg, data_in, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, write_enable, write_reg, data_in, busy_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter: one holding slot per requester, oldest-first drain
// into a registered register-file write port, plus a per-register in-flight mask.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_arbiter_if.slave    wb_if
);

  logic              alu_full_q, alu_full_d;
  logic [ADDR_W-1:0] alu_rd_q, alu_rd_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              mem_full_q, mem_full_d;
  logic [ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              alu_first_q, alu_first_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic grant_alu, grant_mem;
  logic alu_load, mem_load, alu_keep, mem_keep;

  // alu_first_q is only meaningful while both slots are full; ties go to mem.
  assign grant_alu = alu_full_q & (~mem_full_q | alu_first_q);
  assign grant_mem = mem_full_q & (~alu_full_q | ~alu_first_q);

  assign wb_if.alu_ready = ~alu_full_q | grant_alu;
  assign wb_if.mem_ready = ~mem_full_q | grant_mem;

  // rd==0 transfers are accepted but never occupy a slot.
  assign alu_load = wb_if.alu_valid & wb_if.alu_ready & (wb_if.alu_rd != '0);
  assign mem_load = wb_if.mem_valid & wb_if.mem_ready & (wb_if.mem_rd != '0);
  assign alu_keep = alu_full_q & ~grant_alu;
  assign mem_keep = mem_full_q & ~grant_mem;

  always_comb begin
    alu_full_d  = alu_full_q & ~grant_alu;
    alu_rd_d    = alu_rd_q;
    alu_data_d  = alu_data_q;
    mem_full_d  = mem_full_q & ~grant_mem;
    mem_rd_d    = mem_rd_q;
    mem_data_d  = mem_data_q;
    alu_first_d = alu_first_q;
    we_d        = grant_alu | grant_mem;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;

    if (alu_load) begin
      alu_full_d = 1'b1;
      alu_rd_d   = wb_if.alu_rd;
      alu_data_d = wb_if.alu_data;
    end
    if (mem_load) begin
      mem_full_d = 1'b1;
      mem_rd_d   = wb_if.mem_rd;
      mem_data_d = wb_if.mem_data;
    end

    // A freshly loaded entry is always younger than one that stays behind.
    if (alu_load && (mem_load || mem_keep))
      alu_first_d = 1'b0;
    else if (mem_load && alu_keep)
      alu_first_d = 1'b1;

    if (grant_mem) begin
      wreg_d  = mem_rd_q;
      wdata_d = mem_data_q;
    end else if (grant_alu) begin
      wreg_d  = alu_rd_q;
      wdata_d = alu_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full_q  <= 1'b0;
      alu_rd_q    <= '0;
      alu_data_q  <= '0;
      mem_full_q  <= 1'b0;
      mem_rd_q    <= '0;
      mem_data_q  <= '0;
      alu_first_q <= 1'b0;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      alu_full_q  <= alu_full_d;
      alu_rd_q    <= alu_rd_d;
      alu_data_q  <= alu_data_d;
      mem_full_q  <= mem_full_d;
      mem_rd_q    <= mem_rd_d;
      mem_data_q  <= mem_data_d;
      alu_first_q <= alu_first_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  assign wb_if.write_enable = we_q;
  assign wb_if.write_reg    = wreg_q;
  assign wb_if.data_in      = wdata_q;

  // Mask is decoded purely from slot and write-port flops.
  assign wb_if.busy_mask[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
      assign wb_if.busy_mask[gi] = (alu_full_q && alu_rd_q == ADDR_W'(gi)) ||
                                   (mem_full_q && mem_rd_q == ADDR_W'(gi)) ||
                                   (we_q && wreg_q == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: reset, single writes, tie-break,
// age order, rd=0 drop and sustained dual traffic, with a write log and register model.
module tb_regfile_wb_arbiter;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  logic clk;
  logic rst;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) wb_if ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_if (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic [ADDR_W+DATA_W-1:0] wlog[$];
  logic [DATA_W-1:0]        regs[NUM_REGS];

  // Log every write-port pulse and commit it to the register model.
  always @(negedge clk) begin
    if (!rst && wb_if.write_enable) begin
      wlog.push_back({wb_if.write_reg, wb_if.data_in});
      regs[wb_if.write_reg] = wb_if.data_in;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_if.alu_valid = 1'b0;
    wb_if.alu_rd    = '0;
    wb_if.alu_data  = '0;
    wb_if.mem_valid = 1'b0;
    wb_if.mem_rd    = '0;
    wb_if.mem_data  = '0;
  endtask

  initial begin
    int ai;
    int mi;
    logic a_acc;
    logic m_acc;
    logic [ADDR_W+DATA_W-1:0] ent;

    n_vec = 0;
    n_err = 0;
    for (int r = 0; r < NUM_REGS; r++) regs[r] = '0;
    idle_inputs();
    rst = 1'b1;

    // Reset state
    #12;
    check_val("reset_we",     64'(wb_if.write_enable), 64'd0);
    check_val("reset_busy",   64'(wb_if.busy_mask), 64'd0);
    check_val("reset_aready", 64'(wb_if.alu_ready), 64'd1);
    check_val("reset_mready", 64'(wb_if.mem_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Reset with both slots full, pulsed mid-cycle
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd3; wb_if.alu_data = 32'h0000_0003;
    wb_if.mem_valid = 1'b1; wb_if.mem_rd = 5'd4; wb_if.mem_data = 32'h0000_0004;
    step();
    idle_inputs();
    check_val("t1_busy_full",  64'(wb_if.busy_mask), 64'h18);
    check_val("t1_aready_blk", 64'(wb_if.alu_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    check_val("t1_rst_we",     64'(wb_if.write_enable), 64'd0);
    check_val("t1_rst_busy",   64'(wb_if.busy_mask), 64'd0);
    check_val("t1_rst_aready", 64'(wb_if.alu_ready), 64'd1);
    check_val("t1_rst_mready", 64'(wb_if.mem_ready), 64'd1);
    wlog.delete();
    step();
    rst = 1'b0;
    repeat (4) step();
    check_val("t1_no_writes",  64'(wlog.size()), 64'd0);
    check_val("t1_busy_after", 64'(wb_if.busy_mask), 64'd0);

    // Single ALU write
    wlog.delete();
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd5; wb_if.alu_data = 32'hDEAD_BEEF;
    check_val("t2_aready", 64'(wb_if.alu_ready), 64'd1);
    step();
    idle_inputs();
    check_val("t2_we_c0",   64'(wb_if.write_enable), 64'd0);
    check_val("t2_busy_c0", 64'(wb_if.busy_mask), 64'h20);
    step();
    check_val("t2_we_c1",   64'(wb_if.write_enable), 64'd1);
    check_val("t2_wreg",    64'(wb_if.write_reg), 64'd5);
    check_val("t2_wdata",   64'(wb_if.data_in), 64'hDEAD_BEEF);
    check_val("t2_busy_c1", 64'(wb_if.busy_mask), 64'h20);
    step();
    check_val("t2_we_c2",   64'(wb_if.write_enable), 64'd0);
    check_val("t2_busy_c2", 64'(wb_if.busy_mask), 64'd0);
    check_val("t2_nwrites", 64'(wlog.size()), 64'd1);

    // Same-edge load to the same rd: mem drains first
    wlog.delete();
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd7; wb_if.alu_data = 32'h11;
    wb_if.mem_valid = 1'b1; wb_if.mem_rd = 5'd7; wb_if.mem_data = 32'h22;
    step();
    idle_inputs();
    repeat (4) step();
    check_val("t3_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check_val("t3_first",  64'(wlog[0]), 64'({5'd7, 32'h22}));
      check_val("t3_second", 64'(wlog[1]), 64'({5'd7, 32'h11}));
    end
    check_val("t3_reg7", 64'(regs[7]), 64'h11);

    // ALU loaded one cycle before mem, same rd
    wlog.delete();
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd9; wb_if.alu_data = 32'h33;
    step();
    idle_inputs();
    wb_if.mem_valid = 1'b1; wb_if.mem_rd = 5'd9; wb_if.mem_data = 32'h44;
    step();
    idle_inputs();
    repeat (4) step();
    check_val("t4_nwrites", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      check_val("t4_first",  64'(wlog[0]), 64'({5'd9, 32'h33}));
      check_val("t4_second", 64'(wlog[1]), 64'({5'd9, 32'h44}));
    end
    check_val("t4_reg9", 64'(regs[9]), 64'h44);

    // rd=0 is accepted and discarded
    wlog.delete();
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = 5'd0; wb_if.alu_data = 32'h5555_5555;
    check_val("t5_aready", 64'(wb_if.alu_ready), 64'd1);
    step();
    idle_inputs();
    check_val("t5_busy", 64'(wb_if.busy_mask), 64'd0);
    repeat (3) step();
    check_val("t5_nwrites", 64'(wlog.size()), 64'd0);

    // Sustained dual traffic, 4 items per requester
    wlog.delete();
    ai = 0;
    mi = 0;
    for (int cyc = 0; cyc < 20 && (ai < 4 || mi < 4); cyc++) begin
      wb_if.alu_valid = (ai < 4);
      wb_if.alu_rd    = ADDR_W'(10 + ai);
      wb_if.alu_data  = 32'hA000_0000 + 32'(ai);
      wb_if.mem_valid = (mi < 4);
      wb_if.mem_rd    = ADDR_W'(20 + mi);
      wb_if.mem_data  = 32'hB000_0000 + 32'(mi);
      if (cyc == 1) begin
        check_val("t6_aready_c1", 64'(wb_if.alu_ready), 64'd0);
        check_val("t6_mready_c1", 64'(wb_if.mem_ready), 64'd1);
      end
      if (cyc == 2) begin
        check_val("t6_aready_c2", 64'(wb_if.alu_ready), 64'd1);
        check_val("t6_mready_c2", 64'(wb_if.mem_ready), 64'd0);
      end
      a_acc = wb_if.alu_valid && wb_if.alu_ready;
      m_acc = wb_if.mem_valid && wb_if.mem_ready;
      step();
      if (a_acc) ai++;
      if (m_acc) mi++;
    end
    idle_inputs();
    check_val("t6_alu_sent", 64'(ai), 64'd4);
    check_val("t6_mem_sent", 64'(mi), 64'd4);
    repeat (4) step();
    check_val("t6_nwrites", 64'(wlog.size()), 64'd8);
    for (int k = 0; k < 8 && k < wlog.size(); k++) begin
      if (k % 2 == 0) ent = {ADDR_W'(20 + k / 2), 32'hB000_0000 + 32'(k / 2)};
      else            ent = {ADDR_W'(10 + k / 2), 32'hA000_0000 + 32'(k / 2)};
      check_val($sformatf("t6_write%0d", k), 64'(wlog[k]), 64'(ent));
    end
    check_val("t6_busy_end", 64'(wb_if.busy_mask), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: the ALU result path and the load/memory return path. Each requester hands off {rd, data} over a valid/ready handshake into a one-entry holding slot. Pending slots are drained oldest-first into registered write-port outputs that drive the register file's write_enable/write_reg/data_in. A busy mask tells the issue logic which destination registers have writes still in flight.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of register index
NUM_REGS, 32, number of architectural registers (width of busy_mask)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-high
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU slot can accept this cycle
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load slot can accept this cycle
mem_rd  input  ADDR_W  load destination register
mem_data  input  DATA_W  load data
write_enable  output  1  to register file write enable
write_reg  output  ADDR_W  to register file write index
data_in  output  DATA_W  to register file write data
busy_mask  output  NUM_REGS  bit r = write to register r pending

Behaviour:
- Reset (async, rst=1): both slots empty, age state cleared, write_enable=0, write_reg=0, data_in=0, busy_mask=0. In-flight requests are dropped. Outputs are released on the first clk edge after rst falls.
- Handshake: a transfer occurs on an edge where x_valid=1 and x_ready=1.
- x_ready = slot_x empty OR slot_x granted this cycle, so back-to-back refill is allowed. x_ready does not depend on x_valid.
- rd=0: the transfer completes, but the slot is not loaded and no write is ever issued. busy_mask[0] is always 0.
- Each slot holds {rd, data, seq}. seq is a 1-bit age marker recording which slot was loaded earlier.
- Arbitration (combinational, each cycle, over full slots only):
  - one full slot -> grant it;
  - both full -> grant the older;
  - both loaded on the same edge -> grant mem first.
  - This preserves WAW order when both slots hold the same rd.
- Grant edge:
  - the granted slot empties, or refills if its requester transfers on the same edge;
  - write_enable<=1, write_reg<=slot.rd, data_in<=slot.data;
  - with no grant, write_enable<=0 and write_reg/data_in hold their values.
- write_enable is high for exactly one cycle per granted write. The register file commits on the following edge.
- Latency from the handshake edge to write_enable high: 1 cycle when uncontended, 2 cycles when it loses arbitration once. Maximum stall for any slot is 1 grant.
- Throughput: one write per cycle. Sustained dual traffic alternates, with each requester getting 1 write per 2 cycles.
- busy_mask[r] = (slot_alu full AND alu.rd==r) OR (slot_mem full AND mem.rd==r) OR (write_enable AND write_reg==r).
  - It is driven from flops only (no valid->mask combinational path).
  - It clears the cycle after the register file commits.
- Simultaneous accept and grant on the same slot: the new entry is younger than the other slot's current entry.
- Data width: data is passed through unmodified, with no sign or zero manipulation.

Test Plan:
- Reset with both slots full (alu rd=3, mem rd=4) and rst pulsed mid-cycle -> immediately write_enable=0, busy_mask=0, both ready=1. No writes occur after release.
- Single ALU write rd=5, data=0xDEADBEEF -> next cycle write_enable=1, write_reg=5, data_in=0xDEADBEEF for exactly 1 cycle. busy_mask[5]=1 for 2 cycles, then 0.
- Same-edge alu rd=7 (0x11) and mem rd=7 (0x22) -> mem write issued first, ALU write next cycle. Final register 7 = 0x11.
- ALU loaded one cycle before mem, both rd=9 -> ALU write issued first, then mem.
- alu_valid with rd=0 -> alu_ready=1, no write_enable pulse, busy_mask unchanged.
- Both valid held continuously for 8 cycles with distinct rd -> 8 writes alternating mem/alu. Each ready deasserts only while its slot is full and ungranted. No request is lost or duplicated.
